bch_error_locate: RTL

- Stage directly downstream of the Chien search.
- Consumes the per-cycle vector of T+1 scaled sigma terms for each of BITS parallel positions. XOR-sums each position's terms; a zero sum marks an error at that bit.
- Emits a registered error-bit stream aligned to the data stream, counts located roots, and at block end flags the codeword uncorrectable when the root count differs from the locator degree supplied by the key-equation solver.

---
 rtl/bch_error_locate.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/bch_error_locate.sv
// Error locator stage after the Chien search: flags positions whose scaled sigma terms
// XOR to zero, counts the roots per block and checks the count against the locator degree.

`ifndef BCH_PARAMS_DEFINED
`define BCH_PARAMS_DEFINED
`define BCH_PARAMS(m, t) ((((m) & 255) << 8) | ((t) & 255))
`define BCH_M(p) ((((p)) >> 8) & 255)
`define BCH_T(p) (((p)) & 255)
`define BCH_SANE `BCH_PARAMS(4, 2)
`endif

module bch_error_locate #(
    parameter int P    = `BCH_SANE,
    parameter int BITS = 1,
    localparam int M   = `BCH_M(P),
    localparam int T   = `BCH_T(P),
    localparam int CW  = $clog2(T + 2),
    localparam int W   = (T + 1) * M * BITS
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            in_valid,
    input  logic            in_first,
    input  logic            in_last,
    input  logic [W-1:0]    chien,
    input  logic [CW-1:0]   sigma_deg,
    output logic [BITS-1:0] err,
    output logic            err_valid,
    output logic            err_first,
    output logic            err_last,
    output logic [CW-1:0]   err_count,
    output logic            done,
    output logic            uncorrectable
);

    localparam int unsigned CAP = T + 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FINAL} state_t;

    state_t          state_q, state_d;
    logic [BITS-1:0] err_q, err_d;
    logic            err_valid_q, err_valid_d;
    logic            err_first_q, err_first_d;
    logic            err_last_q, err_last_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [CW-1:0]   deg_q, deg_d;
    logic            done_q, done_d;
    logic            unc_q, unc_d;

    logic [BITS-1:0] hit;
    int unsigned     hit_cnt;
    logic            start;

    function automatic logic [M-1:0] pos_sum(input logic [W-1:0] v, input int b);
        logic [M-1:0] s;
        s = '0;
        for (int i = 0; i <= T; i++) begin
            s = s ^ v[(b*(T+1)+i)*M +: M];
        end
        return s;
    endfunction

    function automatic int unsigned popcount(input logic [BITS-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < BITS; i++) begin
            n = n + 32'(v[i]);
        end
        return n;
    endfunction

    // Saturates at T+1 so an overfull block can never alias back to a legal degree.
    function automatic logic [CW-1:0] sat_add(input logic [CW-1:0] a, input int unsigned b);
        int unsigned s;
        s = 32'(a) + b;
        if (s > CAP) begin
            s = CAP;
        end
        return CW'(s);
    endfunction

    always_comb begin
        hit = '0;
        for (int b = 0; b < BITS; b++) begin
            hit[b] = in_valid && (pos_sum(chien, b) == '0);
        end
        hit_cnt = popcount(hit);
        start   = in_valid && in_first;
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        deg_d       = deg_q;
        unc_d       = unc_q;
        done_d      = 1'b0;
        err_d       = hit;
        err_valid_d = in_valid;
        err_first_d = in_valid && in_first;
        err_last_d  = in_valid && in_last;

        // A new block start wins in every state and silently drops any open block.
        if (start) begin
            deg_d   = sigma_deg;
            unc_d   = 1'b0;
            cnt_d   = sat_add('0, hit_cnt);
            state_d = in_last ? S_FINAL : S_RUN;
        end else begin
            case (state_q)
                S_RUN: begin
                    if (in_valid) begin
                        cnt_d = sat_add(cnt_q, hit_cnt);
                        if (in_last) begin
                            state_d = S_FINAL;
                        end
                    end
                end
                S_FINAL: begin
                    done_d  = 1'b1;
                    unc_d   = (cnt_q != deg_q);
                    state_d = S_IDLE;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            err_q       <= '0;
            err_valid_q <= 1'b0;
            err_first_q <= 1'b0;
            err_last_q  <= 1'b0;
            cnt_q       <= '0;
            deg_q       <= '0;
            done_q      <= 1'b0;
            unc_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            err_q       <= err_d;
            err_valid_q <= err_valid_d;
            err_first_q <= err_first_d;
            err_last_q  <= err_last_d;
            cnt_q       <= cnt_d;
            deg_q       <= deg_d;
            done_q      <= done_d;
            unc_q       <= unc_d;
        end
    end

    assign err           = err_q;
    assign err_valid     = err_valid_q;
    assign err_first     = err_first_q;
    assign err_last      = err_last_q;
    assign err_count     = cnt_q;
    assign done          = done_q;
    assign uncorrectable = unc_q;

endmodule
